// File: rtl/ao486_ifill_req_queue_pkg.sv
// ao486_ifill_req_queue_pkg: L1.5 message codes, FSM states and byte-swap helper
package ao486_ifill_req_queue_pkg;

    localparam logic [4:0] IMISS_RQ  = 5'b10000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] INT_RET   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ao486_req_fifo.sv
// ao486_req_fifo: DEPTH x W request FIFO with registered full flag
module ao486_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, do_push, do_pop;

    // Pushes while full are dropped; pops on empty are ignored.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && (count_q != '0);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointers wrap naturally; full is registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Entry storage needs no reset; only valid entries are ever read out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // A dropped push means the core ignored req_full.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push_i && full_q)) else $warning("ao486_req_fifo: push while full dropped");
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ao486_ifill_req_queue.sv
// ao486_ifill_req_queue: buffers ao486 readcode requests and issues them as IMISS to L1.5
module ao486_ifill_req_queue
    import ao486_ifill_req_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_do_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_full_o,
    input  logic              issue_block_i,
    output logic              ifill_val_o,
    output logic [4:0]        ifill_rqtype_o,
    output logic [39:0]       ifill_address_o,
    input  logic              l15_header_ack_i,
    input  logic              l15_val_i,
    input  logic [3:0]        l15_returntype_i,
    input  logic [63:0]       l15_data_2_i,
    input  logic [63:0]       l15_data_3_i,
    output logic [127:0]      readcode_line_o,
    output logic              readcode_done_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, pop, capture;
    logic [127:0]      line_q;

    ao486_req_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_do_i),
        .pop_i   (pop),
        .data_i  (req_addr_i),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (req_full_o),
        .empty_o (fifo_empty)
    );

    // Next state: one miss in flight, issue held off while the transducer blocks.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE:    state_d = (!fifo_empty && !issue_block_i) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                pop     = l15_header_ack_i;
                state_d = l15_header_ack_i ? ST_WAIT : ST_ISSUE;
            end
            ST_WAIT: begin
                capture = l15_val_i && (l15_returntype_i == IFILL_RET);
                state_d = capture ? ST_DELIVER : ST_WAIT;
            end
            ST_DELIVER: state_d = (!fifo_empty && !issue_block_i) ? ST_ISSUE : ST_IDLE;
        endcase
    end

    // State register and returned line, cleared on reset so no stale line leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) line_q <= {bswap32(l15_data_2_i[63:32]), bswap32(l15_data_2_i[31:0]),
                                    bswap32(l15_data_3_i[63:32]), bswap32(l15_data_3_i[31:0])};
        end
    end

    // An IFILL return with no miss outstanding points at a protocol error upstream.
    always_ff @(posedge clk) begin
        if (rst_n && l15_val_i && l15_returntype_i == IFILL_RET)
            assert (state_q == ST_WAIT) else $warning("ao486_ifill_req_queue: IFILL_RET with no miss outstanding");
    end

    assign ifill_val_o     = (state_q == ST_ISSUE);
    assign ifill_rqtype_o  = ifill_val_o ? IMISS_RQ : 5'd0;
    assign ifill_address_o = ifill_val_o ? {{(40-ADDR_W){head[ADDR_W-1]}}, head} : 40'd0;
    assign readcode_line_o = line_q;
    assign readcode_done_o = (state_q == ST_DELIVER);
    assign busy_o          = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ao486_ifill_req_queue.sv
// tb_ao486_ifill_req_queue: directed checks of queueing, issue handshake and line return
module tb_ao486_ifill_req_queue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_do = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         req_full;
    logic         issue_block = 1'b0;
    logic         ifill_val;
    logic [4:0]   ifill_rqtype;
    logic [39:0]  ifill_address;
    logic         l15_header_ack = 1'b0;
    logic         l15_val = 1'b0;
    logic [3:0]   l15_returntype = '0;
    logic [63:0]  l15_data_2 = '0;
    logic [63:0]  l15_data_3 = '0;
    logic [127:0] readcode_line;
    logic         readcode_done;
    logic         busy;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] burst [5] = '{32'h0000_1000, 32'h0000_2000, 32'hC000_3000, 32'h0000_4000, 32'h0000_5000};

    ao486_ifill_req_queue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_do_i         (req_do),
        .req_addr_i       (req_addr),
        .req_full_o       (req_full),
        .issue_block_i    (issue_block),
        .ifill_val_o      (ifill_val),
        .ifill_rqtype_o   (ifill_rqtype),
        .ifill_address_o  (ifill_address),
        .l15_header_ack_i (l15_header_ack),
        .l15_val_i        (l15_val),
        .l15_returntype_i (l15_returntype),
        .l15_data_2_i     (l15_data_2),
        .l15_data_3_i     (l15_data_3),
        .readcode_line_o  (readcode_line),
        .readcode_done_o  (readcode_done),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] bs(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] mkline(input logic [31:0] a);
        return {bs(a), bs(~a), bs(a ^ 32'h5a5a_5a5a), bs(a + 32'd1)};
    endfunction

    task automatic push(input logic [31:0] a);
        req_do = 1'b1;
        req_addr = a;
        step();
        req_do = 1'b0;
    endtask

    task automatic ret(input logic [3:0] t, input logic [31:0] a);
        l15_val = 1'b1;
        l15_returntype = t;
        l15_data_2 = {a, ~a};
        l15_data_3 = {a ^ 32'h5a5a_5a5a, a + 32'd1};
        step();
        l15_val = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [31:0] a);
        int n = 0;
        while (ifill_val !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_val"}, ifill_val, 1'b1);
        chk({tag, "_addr"}, ifill_address, {{8{a[31]}}, a});
        chk({tag, "_rqtype"}, ifill_rqtype, 5'h10);
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
        chk({tag, "_val_drop"}, ifill_val, 1'b0);
        ret(4'h1, a);
        chk({tag, "_done"}, readcode_done, 1'b1);
        chk({tag, "_line"}, readcode_line, mkline(a));
        step();
        chk({tag, "_done_pulse"}, readcode_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_val", ifill_val, 1'b0);
        chk("rst_rqtype", ifill_rqtype, 5'h0);
        chk("rst_addr", ifill_address, 40'h0);
        chk("rst_line", readcode_line, 128'h0);
        chk("rst_done", readcode_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", req_full, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        push(32'h000F_FFF0);
        chk("t1_lat1_val", ifill_val, 1'b0);
        chk("t1_busy", busy, 1'b1);
        step();
        chk("t1_lat2_val", ifill_val, 1'b1);
        chk("t1_addr", ifill_address, 40'h00_000F_FFF0);
        chk("t1_rqtype", ifill_rqtype, 5'h10);
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
        chk("t1_wait_val", ifill_val, 1'b0);
        chk("t1_wait_rqtype", ifill_rqtype, 5'h0);
        l15_val = 1'b1;
        l15_returntype = 4'h1;
        l15_data_2 = 64'h0011_2233_4455_6677;
        l15_data_3 = 64'h8899_AABB_CCDD_EEFF;
        step();
        l15_val = 1'b0;
        chk("t1_done", readcode_done, 1'b1);
        chk("t1_line_hi", readcode_line[127:64], 64'h3322_1100_7766_5544);
        chk("t1_line", readcode_line, 128'h3322_1100_7766_5544_BBAA_9988_FFEE_DDCC);
        step();
        chk("t1_done_pulse", readcode_done, 1'b0);
        chk("t1_line_hold", readcode_line, 128'h3322_1100_7766_5544_BBAA_9988_FFEE_DDCC);
        chk("t1_idle_busy", busy, 1'b0);

        push(32'h8000_0000);
        step();
        chk("t2_addr_sext", ifill_address, 40'hFF_8000_0000);
        serve("t2", 32'h8000_0000);

        for (int i = 0; i < 5; i++) begin
            push(burst[i]);
            if (i == 2) chk("t3_not_full", req_full, 1'b0);
            if (i >= 3) chk($sformatf("t3_full_%0d", i), req_full, 1'b1);
        end
        chk("t3_count", dut.fifo_count, 3'd4);
        for (int i = 0; i < 4; i++) serve($sformatf("t3_drain%0d", i), burst[i]);
        chk("t3_empty_busy", busy, 1'b0);
        chk("t3_empty_full", req_full, 1'b0);

        push(32'h0000_00A0);
        push(32'h0000_00A1);
        chk("t4_count2", dut.fifo_count, 3'd2);
        chk("t4_issue_head", ifill_address, 40'h00_0000_00A0);
        req_do = 1'b1;
        req_addr = 32'h0000_00A2;
        l15_header_ack = 1'b1;
        step();
        req_do = 1'b0;
        l15_header_ack = 1'b0;
        chk("t4_pushpop_count", dut.fifo_count, 3'd2);
        chk("t4_wait_val", ifill_val, 1'b0);
        ret(4'h1, 32'h0000_00A0);
        chk("t4_done", readcode_done, 1'b1);
        chk("t4_line", readcode_line, mkline(32'h0000_00A0));
        step();
        serve("t4_a1", 32'h0000_00A1);
        serve("t4_a2_wrap", 32'h0000_00A2);

        issue_block = 1'b1;
        push(32'h0000_00B0);
        step();
        step();
        chk("t5_blocked_val", ifill_val, 1'b0);
        chk("t5_blocked_busy", busy, 1'b1);
        issue_block = 1'b0;
        step();
        chk("t5_release_val", ifill_val, 1'b1);
        issue_block = 1'b1;
        step();
        chk("t5_no_retract", ifill_val, 1'b1);
        issue_block = 1'b0;
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
        ret(4'h7, 32'h0000_0BAD);
        chk("t5_intret_done", readcode_done, 1'b0);
        chk("t5_intret_line", readcode_line, mkline(32'h0000_00A2));
        chk("t5_intret_val", ifill_val, 1'b0);
        ret(4'h1, 32'h0000_00B0);
        chk("t5_done", readcode_done, 1'b1);
        chk("t5_line", readcode_line, mkline(32'h0000_00B0));
        step();

        push(32'h0000_00C0);
        step();
        chk("t6_issue", ifill_val, 1'b1);
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
        chk("t6_wait_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_val", ifill_val, 1'b0);
        chk("t6_rst_rqtype", ifill_rqtype, 5'h0);
        chk("t6_rst_addr", ifill_address, 40'h0);
        chk("t6_rst_done", readcode_done, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_line", readcode_line, 128'h0);
        chk("t6_rst_full", req_full, 1'b0);
        step();
        rst_n = 1'b1;
        ret(4'h1, 32'h0000_00C0);
        chk("t6_late_done", readcode_done, 1'b0);
        chk("t6_late_busy", busy, 1'b0);
        step();
        chk("t6_late_done2", readcode_done, 1'b0);
        chk("t6_late_line", readcode_line, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
